// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch requester, data requester and memory port.
// The arbiter uses the master view; the requesters and memory together use the slave view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_rdata, mem_ready,
    output if_ack, if_rdata,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_rdata, mem_ready,
    input  if_ack, if_rdata,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction
// at a time, with ties going to whichever requester was not served last.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic take_any;
  logic take_data;

  // Data wins when it is alone, or on a tie when fetch was the previous winner.
  assign take_any  = bus.if_req | bus.d_req;
  assign take_data = bus.d_req & (~bus.if_req | (last_grant_q == GNT_FETCH));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (take_any) begin
          state_d   = BUSY;
          mem_req_d = 1'b1;
          if (take_data) begin
            last_grant_d = GNT_DATA;
            mem_we_d     = bus.d_we;
            mem_addr_d   = bus.d_addr;
            mem_wdata_d  = bus.d_wdata;
            mem_be_d     = bus.d_be;
          end else begin
            last_grant_d = GNT_FETCH;
            mem_we_d     = 1'b0;
            mem_addr_d   = bus.if_addr;
            mem_wdata_d  = '0;
            mem_be_d     = 4'hF;
          end
        end
      end

      BUSY: begin
        // last_grant_q doubles as the current grant for the whole transaction.
        if (bus.mem_ready) begin
          state_d   = ACK;
          mem_req_d = 1'b0;
          if (last_grant_q == GNT_FETCH) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_FETCH;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= 4'h0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard of expected grants is filled as
// requests are raised and drained as the memory port and acks show each transaction.
module tb_mem_port_arbiter;

  typedef struct {
    logic        isData;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } txn_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  txn_t expQ[$];
  logic [31:0] ifRdataModel;
  logic [31:0] dRdataModel;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_memReq"},   {31'd0, bus.mem_req}, 32'd0);
    checkOutput({pfx, "_memWe"},    {31'd0, bus.mem_we},  32'd0);
    checkOutput({pfx, "_memAddr"},  bus.mem_addr,         32'd0);
    checkOutput({pfx, "_memWdata"}, bus.mem_wdata,        32'd0);
    checkOutput({pfx, "_memBe"},    {28'd0, bus.mem_be},  32'd0);
    checkOutput({pfx, "_ifAck"},    {31'd0, bus.if_ack},  32'd0);
    checkOutput({pfx, "_dAck"},     {31'd0, bus.d_ack},   32'd0);
    checkOutput({pfx, "_ifRdata"},  bus.if_rdata,         32'd0);
    checkOutput({pfx, "_dRdata"},   bus.d_rdata,          32'd0);
  endtask

  task automatic applyStimulus(input logic isData, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [31:0] rdata);
    txn_t t;
    t.isData = isData;
    t.we     = isData ? we : 1'b0;
    t.addr   = addr;
    t.wdata  = wdata;
    t.be     = isData ? be : 4'hF;
    t.rdata  = rdata;
    expQ.push_back(t);
  endtask

  task automatic checkFields(input string pfx, input txn_t t);
    checkOutput({pfx, "_memReq"},  {31'd0, bus.mem_req}, 32'd1);
    checkOutput({pfx, "_memWe"},   {31'd0, bus.mem_we},  {31'd0, t.we});
    checkOutput({pfx, "_memAddr"}, bus.mem_addr,         t.addr);
    checkOutput({pfx, "_memBe"},   {28'd0, bus.mem_be},  {28'd0, t.be});
    if (t.we) checkOutput({pfx, "_memWdata"}, bus.mem_wdata, t.wdata);
  endtask

  // Serves the oldest expected transaction: waits for mem_req, inserts wait states,
  // completes it, then checks the one-cycle ack and the registered read data.
  task automatic runTxn(input int waitCycles, input bit dropReq);
    txn_t t;
    bit   seen;
    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 32'd1, 32'd0);
      return;
    end
    t = expQ.pop_front();
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      step();
      seen = bus.mem_req;
    end
    checkOutput("memReqSeen", {31'd0, seen}, 32'd1);
    if (!seen) return;
    checkFields("grant", t);
    for (int i = 0; i < waitCycles; i++) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      step();
      checkFields("wait", t);
      checkOutput("waitNoAck", {31'd0, bus.if_ack | bus.d_ack}, 32'd0);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = t.rdata;
    step();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hA5A5_5A5A;
    if (t.isData) begin
      if (!t.we) dRdataModel = t.rdata;
    end else begin
      ifRdataModel = t.rdata;
    end
    checkOutput("ackIf",     {31'd0, bus.if_ack},  {31'd0, !t.isData});
    checkOutput("ackD",      {31'd0, bus.d_ack},   {31'd0, t.isData});
    checkOutput("ackMemReq", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("ifRdata",   bus.if_rdata,         ifRdataModel);
    checkOutput("dRdata",    bus.d_rdata,          dRdataModel);
    if (dropReq) begin
      if (t.isData) bus.d_req = 1'b0;
      else          bus.if_req = 1'b0;
    end
    step();
    checkOutput("ackPulse", {31'd0, bus.if_ack | bus.d_ack}, 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ifRdataModel = 32'd0;
    dRdataModel  = 32'd0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'd0;
    bus.d_wdata   = 32'd0;
    bus.d_be      = 4'h0;
    bus.mem_rdata = 32'd0;
    bus.mem_ready = 1'b0;
    doReset();
    checkResetValues("reset");

    $display("[TB] spurious ready while idle");
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("spurAck",    {31'd0, bus.if_ack | bus.d_ack}, 32'd0);
      checkOutput("spurMemReq", {31'd0, bus.mem_req},            32'd0);
      checkOutput("spurIfRd",   bus.if_rdata,                    32'd0);
    end
    bus.mem_ready = 1'b0;

    $display("[TB] single fetch");
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    applyStimulus(1'b0, 1'b0, 32'h100, 32'd0, 4'hF, 32'hE3A0_0001);
    runTxn(0, 1'b1);

    $display("[TB] tie after reset");
    doReset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h104;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_be    = 4'h3;
    applyStimulus(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'h3, 32'h5555_5555);
    applyStimulus(1'b0, 1'b0, 32'h104, 32'd0, 4'hF, 32'h1234_5678);
    runTxn(0, 1'b1);
    runTxn(0, 1'b1);

    $display("[TB] alternation with both requests held");
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h108;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h300;
    bus.d_be    = 4'hF;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, 1'b0, 32'h300, 32'd0, 4'hF, 32'h1000_0000 + i);
      else            applyStimulus(1'b0, 1'b0, 32'h108, 32'd0, 4'hF, 32'h2000_0000 + i);
    end
    for (int i = 0; i < 6; i++) runTxn(i % 2, i >= 4);

    $display("[TB] wait states on a store");
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h3FC;
    bus.d_wdata = 32'hCAFE_F00D;
    bus.d_be    = 4'hC;
    applyStimulus(1'b1, 1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hC, 32'h7777_7777);
    runTxn(5, 1'b1);

    $display("[TB] reset in the middle of a load");
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h400;
    step();
    checkOutput("midMemReq1", {31'd0, bus.mem_req}, 32'd1);
    checkOutput("midAddr1",   bus.mem_addr,         32'h400);
    step();
    checkOutput("midMemReq2", {31'd0, bus.mem_req}, 32'd1);
    rst       = 1'b1;
    bus.d_req = 1'b0;
    step();
    rst = 1'b0;
    ifRdataModel = 32'd0;
    dRdataModel  = 32'd0;
    checkResetValues("midBusy");
    step();
    checkOutput("postRstAck",    {31'd0, bus.if_ack | bus.d_ack}, 32'd0);
    checkOutput("postRstMemReq", {31'd0, bus.mem_req},            32'd0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h180;
    applyStimulus(1'b0, 1'b0, 32'h180, 32'd0, 4'hF, 32'hE1A0_F00E);
    runTxn(2, 1'b1);

    checkOutput("scoreboardDrained", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single memory port between the instruction-fetch requester and the data-access requester, which the microsequenced control states drive for loads and stores. Requests are registered into a latched transaction, held on the memory port until the memory signals completion, and acknowledged back to the winning requester with registered read data. Ties go to the requester not served last, so neither fetch nor data can starve the other.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse; fetch transaction complete
- if_rdata  out  DATA_W  fetched word; valid while if_ack=1, held until next fetch ack
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  4  store byte enables
- d_ack  out  1  one-cycle pulse; data transaction complete
- d_rdata  out  DATA_W  load data; updated only on load acks
- mem_req  out  1  transaction active on memory port
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_be  out  4  latched byte enables
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the active transaction this cycle

## Operation
- States: IDLE, BUSY, ACK. Reset state: IDLE.
- IDLE: samples if_req/d_req.
  - Neither: stay.
  - One: grant it.
  - Both: grant the requester not in last_grant. last_grant resets to FETCH, so data wins the first tie.
  - On grant:
    - Latch the granted requester's addr, we, wdata and be into the mem_* registers.
    - Fetch uses mem_we=0 and mem_be=4'hF.
    - Set grant and last_grant, then go to BUSY.
- BUSY: mem_req=1, and all mem_* outputs are held constant.
  - mem_ready=0: stay.
  - mem_ready=1: capture mem_rdata into if_rdata (fetch) or d_rdata (data load only), set the matching ack register, and go to ACK.
- ACK: the ack pulse is visible this cycle and mem_req=0. Go to IDLE unconditionally.
  - Requesters deassert req in the ack cycle.
  - Requests are not sampled in ACK.
- mem_ready outside BUSY is ignored.
- Only one transaction is outstanding at a time, and if_ack and d_ack are never high together.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, last_grant=FETCH.
- Reset mid-BUSY:
  - Abandons the transaction. The next cycle shows mem_req=0, no ack pulse, state IDLE.
  - The memory model must tolerate the withdrawn request.
- A request that drops while BUSY does not cancel the transaction, and the ack is still pulsed.

## Timing
- Cycle 0: IDLE, req sampled. Cycle 1: mem_req=1 with latched fields.
- mem_ready at cycle k (k≥1) gives ack at k+1, and IDLE samples again at k+2.
- Minimum turnaround is 3 cycles per transaction; back-to-back throughput is 1 transaction per (memory latency + 2) cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x100; mem_ready asserted in the first mem_req cycle with mem_rdata=0xE3A00001.
  - Required: mem_req in cycle 1 with mem_addr=0x100, mem_we=0, mem_be=F; if_ack in cycle 2 with if_rdata=0xE3A00001; d_ack stays 0.
- Tie after reset:
  - Stimulus: if_req and d_req both high in the same IDLE cycle; d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=0x3.
  - Required: data is granted first with mem_we=1, mem_be=3; d_rdata unchanged on its ack; fetch is granted in the next IDLE.
- Alternation:
  - Stimulus: both requests held continuously for 6 transactions.
  - Required: grants alternate D,F,D,F,D,F; no requester waits more than one transaction.
- Wait states:
  - Stimulus: memory holds mem_ready=0 for 5 cycles.
  - Required: mem_addr, mem_we, mem_wdata and mem_be stable for the whole time; exactly one ack, on the cycle after mem_ready.
- Reset mid-BUSY:
  - Stimulus: rst=1 during cycle 2 of a data load.
  - Required: next cycle mem_req=0, d_ack=0, all outputs at reset values; a new fetch afterwards completes normally.
- Spurious ready:
  - Stimulus: mem_ready=1 while IDLE with no request.
  - Required: no ack and no state change.
